intr_ctrl: RTL and testbench

//  Bus-attached priority interrupt controller between the INTR outputs of the

---
 rtl/intr_ctrl.sv | 128 ++++++++++++
 tb/tb_intr_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Priority interrupt controller: latches masked level requests, raises IRQ,
// hands the winning vector to the CPU on IACK and tracks in-service nesting.
module intr_ctrl #(
  parameter int               ABITS = 32,
  parameter int               DBITS = 32,
  parameter logic [ABITS-1:0] RBASE = 32'hF000_0100,
  parameter int               NSRC  = 8,
  parameter int               IDXB  = 3
) (
  input  logic             CLK,
  input  logic             INIT_N,
  input  logic             LOCK,
  input  logic [ABITS-1:0] ABUS,
  inout  wire  [DBITS-1:0] RBUS,
  input  logic             RE,
  input  logic [DBITS-1:0] WBUS,
  input  logic             WE,
  input  logic [NSRC-1:0]  SRC,
  input  logic             IACK,
  output logic             IRQ
);

  localparam logic [ABITS-1:0] A_PEND = RBASE;
  localparam logic [ABITS-1:0] A_MASK = RBASE + ABITS'(4);
  localparam logic [ABITS-1:0] A_ISR  = RBASE + ABITS'(8);
  localparam logic [ABITS-1:0] A_VEC  = RBASE + ABITS'(12);
  localparam logic [ABITS-1:0] A_EOI  = RBASE + ABITS'(16);
  localparam logic [ABITS-1:0] A_CTRL = RBASE + ABITS'(20);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            state;
  logic [NSRC-1:0]   mask, isr, isr_d, allow, cand, eoi_bit;
  logic              gie, vec_vld, elig, blk, rsel;
  logic [IDXB-1:0]   vec_idx, win;
  logic [DBITS-1:0]  rdata;
  logic              wr_mask, wr_ctrl, wr_eoi;

  wire unused_wbus = &{1'b0, WBUS[DBITS-1:NSRC]};

  function automatic logic [IDXB-1:0] lsb_idx(input logic [NSRC-1:0] v);
    lsb_idx = '0;
    for (int i = NSRC-1; i >= 0; i--)
      if (v[i]) lsb_idx = IDXB'(i);
  endfunction

  // A source may nest only if no in-service bit sits at or below its index.
  always_comb begin
    allow = '0;
    blk   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      blk      = blk | isr[i];
      allow[i] = ~blk;
    end
  end

  assign cand    = SRC & mask & allow;
  assign elig    = gie & (|cand);
  assign win     = lsb_idx(cand);
  assign eoi_bit = isr & (~isr + NSRC'(1));

  assign wr_mask = WE && (ABUS == A_MASK);
  assign wr_ctrl = WE && (ABUS == A_CTRL);
  assign wr_eoi  = WE && (ABUS == A_EOI);

  // EOI clear lands first; an acknowledge in the same cycle sets on top of it.
  always_comb begin
    isr_d = wr_eoi ? (isr & ~eoi_bit) : isr;
    if (state == S_REQ && IACK && elig)
      isr_d = isr_d | (NSRC'(1) << win);
  end

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      state   <= S_IDLE;
      mask    <= '0;
      isr     <= '0;
      gie     <= 1'b0;
      vec_vld <= 1'b0;
      vec_idx <= '0;
      IRQ     <= 1'b0;
    end else if (LOCK) begin
      if (wr_mask) mask <= WBUS[NSRC-1:0];
      if (wr_ctrl) gie  <= WBUS[0];
      isr <= isr_d;
      case (state)
        S_IDLE: begin
          if (elig) begin
            state <= S_REQ;
            IRQ   <= 1'b1;
          end
        end
        S_REQ: begin
          if (IACK) begin
            state   <= S_IDLE;
            IRQ     <= 1'b0;
            vec_vld <= elig;
            vec_idx <= elig ? win : '1;
          end else if (!elig) begin
            state <= S_IDLE;
            IRQ   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    rsel  = 1'b1;
    case (ABUS)
      A_PEND: rdata[NSRC-1:0] = SRC & mask;
      A_MASK: rdata[NSRC-1:0] = mask;
      A_ISR:  rdata[NSRC-1:0] = isr;
      A_VEC: begin
        rdata[8]        = vec_vld;
        rdata[IDXB-1:0] = vec_idx;
      end
      A_EOI:  rdata = '0;
      A_CTRL: rdata[0] = gie;
      default: rsel = 1'b0;
    endcase
  end

  assign RBUS = (RE && rsel) ? rdata : 'z;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: nesting, spurious acks, EOI/IACK overlap,
// async reset, LOCK hold and bus register access.
module tb_intr_ctrl;
  localparam logic [31:0] RB     = 32'hF000_0100;
  localparam logic [31:0] R_PEND = RB + 32'h00;
  localparam logic [31:0] R_MASK = RB + 32'h04;
  localparam logic [31:0] R_ISR  = RB + 32'h08;
  localparam logic [31:0] R_VEC  = RB + 32'h0C;
  localparam logic [31:0] R_EOI  = RB + 32'h10;
  localparam logic [31:0] R_CTRL = RB + 32'h14;

  logic        clk = 1'b0;
  logic        init_n, lock, re, we, iack, irq;
  logic [31:0] abus, wbus;
  logic [7:0]  src;
  wire  [31:0] rbus;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  intr_ctrl #(.ABITS(32), .DBITS(32), .RBASE(RB), .NSRC(8), .IDXB(3)) dut (
    .CLK(clk), .INIT_N(init_n), .LOCK(lock), .ABUS(abus), .RBUS(rbus),
    .RE(re), .WBUS(wbus), .WE(we), .SRC(src), .IACK(iack), .IRQ(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    abus = a; wbus = d; we = 1'b1;
    tick();
    we = 1'b0; abus = '0; wbus = '0;
  endtask

  task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    abus = a; re = 1'b1;
    #1 d = rbus;
    re = 1'b0; abus = '0;
    chk(tag, d, exp);
  endtask

  task automatic zchk(input string tag, input logic [31:0] a, input logic r);
    logic ok;
    abus = a; re = r;
    #1 ok = $isunknown(rbus) || (rbus == 32'h0);
    re = 1'b0; abus = '0;
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic ack();
    iack = 1'b1;
    tick();
    iack = 1'b0;
  endtask

  initial begin
    init_n = 1'b0; lock = 1'b1; re = 1'b0; we = 1'b0; iack = 1'b0;
    abus = '0; wbus = '0; src = '0;
    tick(); tick();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rchk("rst_mask", R_MASK, 32'h0);
    rchk("rst_vec", R_VEC, 32'h0);
    init_n = 1'b1;
    tick();

    // 1: basic request and acknowledge
    wr(R_MASK, 32'h04);
    wr(R_CTRL, 32'h01);
    src = 8'h04;
    chk("t1_irq_pre", {31'd0, irq}, 32'd0);
    tick();
    chk("t1_irq_up", {31'd0, irq}, 32'd1);
    ack();
    chk("t1_irq_ack", {31'd0, irq}, 32'd0);
    rchk("t1_vec", R_VEC, 32'h102);
    rchk("t1_isr", R_ISR, 32'h04);
    tick();
    chk("t1_irq_gap", {31'd0, irq}, 32'd0);

    // 2: nesting blocked, then higher priority nests
    src = 8'h24;
    tick(); tick();
    chk("t2_blocked", {31'd0, irq}, 32'd0);
    src = 8'h25;
    wr(R_MASK, 32'h05);
    chk("t2_mask_lat", {31'd0, irq}, 32'd0);
    tick();
    chk("t2_irq_up", {31'd0, irq}, 32'd1);
    ack();
    rchk("t2_vec", R_VEC, 32'h100);
    rchk("t2_isr", R_ISR, 32'h05);
    wr(R_EOI, 32'h0);
    src = 8'h00;
    rchk("t2_eoi1", R_ISR, 32'h04);
    wr(R_EOI, 32'h0);
    rchk("t2_eoi2", R_ISR, 32'h00);

    // 3: source drop and spurious ack
    src = 8'h04;
    tick();
    chk("t3_irq_up", {31'd0, irq}, 32'd1);
    src = 8'h00;
    tick();
    chk("t3_drop", {31'd0, irq}, 32'd0);
    src = 8'h04;
    tick();
    chk("t3_irq_up2", {31'd0, irq}, 32'd1);
    src = 8'h00; iack = 1'b1;
    tick();
    iack = 1'b0;
    chk("t3_sp_irq", {31'd0, irq}, 32'd0);
    rchk("t3_sp_vec", R_VEC, 32'h007);
    rchk("t3_sp_isr", R_ISR, 32'h00);
    // CTRL write in the IACK cycle: ack still uses the old GIE
    src = 8'h04;
    tick();
    chk("t3_irq_up3", {31'd0, irq}, 32'd1);
    abus = R_CTRL; wbus = 32'h0; we = 1'b1; iack = 1'b1;
    tick();
    we = 1'b0; iack = 1'b0; abus = '0;
    rchk("t3_ctl_vec", R_VEC, 32'h102);
    rchk("t3_ctl_isr", R_ISR, 32'h04);
    rchk("t3_ctl_gie", R_CTRL, 32'h0);
    wr(R_EOI, 32'h0);
    src = 8'h00;
    rchk("t3_isr_clr", R_ISR, 32'h00);

    // 4: EOI and IACK together; eligibility uses the pre-EOI ISR
    wr(R_MASK, 32'h0D);
    wr(R_CTRL, 32'h01);
    src = 8'h04;
    tick();
    ack();
    rchk("t4_isr_a", R_ISR, 32'h04);
    src = 8'h01;
    tick();
    chk("t4_irq_nest", {31'd0, irq}, 32'd1);
    src = 8'h08; abus = R_EOI; we = 1'b1; iack = 1'b1;
    tick();
    we = 1'b0; iack = 1'b0; abus = '0;
    rchk("t4_pre_vec", R_VEC, 32'h007);
    rchk("t4_pre_isr", R_ISR, 32'h00);
    tick();
    chk("t4_irq_s3", {31'd0, irq}, 32'd1);
    ack();
    rchk("t4_vec3", R_VEC, 32'h103);
    rchk("t4_isr3", R_ISR, 32'h08);
    src = 8'h01;
    tick();
    chk("t4_irq_s0", {31'd0, irq}, 32'd1);
    abus = R_EOI; we = 1'b1; iack = 1'b1;
    tick();
    we = 1'b0; iack = 1'b0; abus = '0;
    rchk("t4_both_isr", R_ISR, 32'h01);
    rchk("t4_both_vec", R_VEC, 32'h100);
    wr(R_EOI, 32'h0);

    // 5: async reset mid-request, then LOCK hold
    tick();
    chk("t5_irq_req", {31'd0, irq}, 32'd1);
    #2 init_n = 1'b0;
    #1 chk("t5_irq_async", {31'd0, irq}, 32'd0);
    rchk("t5_mask", R_MASK, 32'h0);
    rchk("t5_ctrl", R_CTRL, 32'h0);
    rchk("t5_vec", R_VEC, 32'h0);
    rchk("t5_isr", R_ISR, 32'h0);
    tick();
    init_n = 1'b1;
    src = 8'h00;
    wr(R_MASK, 32'h01);
    wr(R_CTRL, 32'h01);
    lock = 1'b0; src = 8'h01;
    tick(); tick(); tick();
    chk("t5_lock_irq", {31'd0, irq}, 32'd0);
    wr(R_MASK, 32'h00);
    rchk("t5_lock_mask", R_MASK, 32'h01);
    lock = 1'b1;
    tick();
    chk("t5_unlock", {31'd0, irq}, 32'd1);
    lock = 1'b0; src = 8'h00;
    tick(); tick();
    chk("t5_hold", {31'd0, irq}, 32'd1);
    lock = 1'b1;
    tick();
    chk("t5_drop", {31'd0, irq}, 32'd0);

    // 6: register reads, read-only writes, undriven bus
    wr(R_CTRL, 32'h0);
    src = 8'hFF;
    wr(R_MASK, 32'h81);
    rchk("t6_pend", R_PEND, 32'h81);
    rchk("t6_mask", R_MASK, 32'h81);
    rchk("t6_ctrl", R_CTRL, 32'h0);
    rchk("t6_eoi", R_EOI, 32'h0);
    wr(R_PEND, 32'hFF);
    wr(R_ISR, 32'hFF);
    wr(R_VEC, 32'h1FF);
    rchk("t6_ro_isr", R_ISR, 32'h0);
    rchk("t6_ro_vec", R_VEC, 32'h0);
    rchk("t6_ro_pend", R_PEND, 32'h81);
    zchk("t6_z_nore", R_MASK, 1'b0);
    zchk("t6_z_addr", RB + 32'h18, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
